// File: rtl/feeder_pkg.sv
// Shared types and constants for the unified-buffer activation feeder.
package feeder_pkg;

  localparam int UB_DEPTH   = 64;
  localparam int ADDR_WIDTH = 6;
  localparam int VCNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/skew_line.sv
// One lane of the diagonal skew: data plus valid delayed by DELAY cycles.
// DELAY of 0 is a plain wire.
module skew_line #(
  parameter int DELAY = 0,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  output logic [WIDTH-1:0] dout,
  output logic             vout
);

  generate
    if (DELAY == 0) begin : g_wire
      logic unused_ctrl_s;
      assign unused_ctrl_s = clk ^ rst;
      assign dout = din;
      assign vout = vin;
    end else begin : g_shift
      logic [DELAY-1:0][WIDTH-1:0] data_r;
      logic [DELAY-1:0]            valid_r;

      // shift register, cleared by synchronous reset
      always_ff @(posedge clk) begin
        if (rst) begin
          data_r  <= '0;
          valid_r <= '0;
        end else begin
          data_r[0]  <= din;
          valid_r[0] <= vin;
          for (int i = 1; i < DELAY; i++) begin
            data_r[i]  <= data_r[i-1];
            valid_r[i] <= valid_r[i-1];
          end
        end
      end

      assign dout = data_r[DELAY-1];
      assign vout = valid_r[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/ub_act_feeder.sv
// Reads num_vec SIZE-element vectors from the unified buffer and feeds them
// diagonally skewed into the systolic array. Optional FEEDER_CYCLE_CNT_EN adds cycle_cnt.
module ub_act_feeder #(
  parameter int SIZE             = 8,
  parameter int ACTIVATION_WIDTH = 7,
  parameter int ADDR_WIDTH       = feeder_pkg::ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [feeder_pkg::VCNT_W-1:0]    num_vec,
  output logic                             busy,
  output logic                             done,
  output logic [ADDR_WIDTH-1:0]            Rd_Addr,
  input  logic [ACTIVATION_WIDTH-1:0]      Rd_Data,
  output logic [SIZE*ACTIVATION_WIDTH-1:0] act_out,
  output logic [SIZE-1:0]                  act_valid
`ifdef FEEDER_CYCLE_CNT_EN
  ,
  output logic [15:0]                      cycle_cnt
`endif
);

  import feeder_pkg::*;

  localparam int AW = ACTIVATION_WIDTH;
  localparam int EW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int DW = $clog2(SIZE + 1);
  localparam logic [EW-1:0]     ELEM_LAST = EW'(SIZE - 1);
  localparam logic [VCNT_W-1:0] SIZE_V    = VCNT_W'(SIZE);

  feeder_state_e state_r, next_state_s;

  logic [EW-1:0]             elem_r;
  logic [VCNT_W-1:0]         vec_r;
  logic [VCNT_W-1:0]         num_r;
  logic [DW-1:0]             drain_r;
  logic [ADDR_WIDTH-1:0]     addr_r;
  logic                      busy_r;
  logic                      done_r;
  logic [SIZE-2:0][AW-1:0]   stage_r;
  logic [SIZE*AW-1:0]        vec0_r;
  logic                      vec0_v_r;

  logic [VCNT_W-1:0] num_clamp_s;
  logic [DW-1:0]     drain_done_at_s;
  logic              accept_s;
  logic              capture_s;
  logic              last_elem_s;
  logic              last_cap_s;
  logic              vec_fire_s;
  logic              done_next_s;
  logic              leave_drain_s;

  assign num_clamp_s     = (num_vec > SIZE_V) ? SIZE_V : num_vec;
  // an empty job drains for zero cycles, so done comes straight away
  assign drain_done_at_s = (num_r == VCNT_W'(0)) ? DW'(0) : DW'(SIZE - 2);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = (num_clamp_s == VCNT_W'(0)) ? DRAIN : LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (last_cap_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = LOAD;
        end
      end
      DRAIN: begin
        if (leave_drain_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    accept_s      = 1'b0;
    capture_s     = 1'b0;
    last_elem_s   = (elem_r == ELEM_LAST);
    last_cap_s    = 1'b0;
    vec_fire_s    = 1'b0;
    done_next_s   = 1'b0;
    leave_drain_s = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = start;
      end
      LOAD: begin
        capture_s  = 1'b1;
        vec_fire_s = last_elem_s;
        last_cap_s = last_elem_s && (vec_r == (num_r - VCNT_W'(1)));
      end
      DRAIN: begin
        done_next_s   = (drain_r == drain_done_at_s);
        leave_drain_s = (drain_r == (drain_done_at_s + DW'(1)));
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  // job control: counters, address, busy/done
  always_ff @(posedge clk) begin
    if (rst) begin
      elem_r  <= '0;
      vec_r   <= '0;
      num_r   <= '0;
      drain_r <= '0;
      addr_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r  <= (next_state_s != IDLE);
      done_r  <= done_next_s;
      drain_r <= (state_r == DRAIN) ? (drain_r + DW'(1)) : DW'(0);
      if (accept_s) begin
        num_r  <= num_clamp_s;
        elem_r <= '0;
        vec_r  <= '0;
        if (num_clamp_s != VCNT_W'(0)) begin
          addr_r <= base_addr;
        end
      end else if (capture_s) begin
        elem_r <= last_elem_s ? EW'(0) : (elem_r + EW'(1));
        if (last_elem_s) begin
          vec_r <= vec_r + VCNT_W'(1);
        end
        // address stays on the final element once the job is fully read
        if (!last_cap_s) begin
          addr_r <= addr_r + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // element staging and skew stage 0
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r  <= '0;
      vec0_r   <= '0;
      vec0_v_r <= 1'b0;
    end else begin
      if (capture_s && !last_elem_s) begin
        stage_r[elem_r] <= Rd_Data;
      end
      vec0_r   <= vec_fire_s ? {Rd_Data, stage_r} : '0;
      vec0_v_r <= vec_fire_s;
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    skew_line #(
      .DELAY (i),
      .WIDTH (AW)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .din  (vec0_r[i*AW +: AW]),
      .vin  (vec0_v_r),
      .dout (act_out[i*AW +: AW]),
      .vout (act_valid[i])
    );
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign Rd_Addr = addr_r;

`ifdef FEEDER_CYCLE_CNT_EN
  logic [15:0] cycle_cnt_r;

  // busy-cycle counter, saturating, frozen from the done cycle on
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_r <= 16'h0000;
    end else if (accept_s) begin
      cycle_cnt_r <= 16'h0000;
    end else if (busy_r && !done_r && (cycle_cnt_r != 16'hFFFF)) begin
      cycle_cnt_r <= cycle_cnt_r + 16'h0001;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign cycle_cnt = cycle_cnt_r;
`endif

endmodule

// File: doc/ub_act_feeder.md
Name: ub_act_feeder

Overview:
- Downstream consumer of the unified buffer: reads activations one element per cycle through the buffer's single combinational read port.
- Assembles SIZE-element vectors and emits them diagonally skewed (lane i delayed i cycles) into the SIZE-row systolic array.
- One job = num_vec consecutive vectors starting at base_addr; started by a pulse, ends with a done pulse.

Parameters:
- SIZE, 8, array rows / lanes per vector
- ACTIVATION_WIDTH, 7, signed activation width
- ADDR_WIDTH, 6, unified buffer address width (depth 64)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  job request; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first buffer address of the job
- num_vec  in  4  vectors in the job, 0..SIZE; values >SIZE clamp to SIZE
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- Rd_Addr  out  ADDR_WIDTH  unified buffer read address
- Rd_Data  in  ACTIVATION_WIDTH  unified buffer read data, combinational from Rd_Addr
- act_out  out  SIZE*ACTIVATION_WIDTH  skewed lanes; lane i at bits [i*AW +: AW]
- act_valid  out  SIZE  per-lane valid

Behaviour:
- Single clock clk; reset rst synchronous, active-high.
- Reset values: busy=0, done=0, Rd_Addr=0, act_out=0, act_valid=0, FSM=IDLE, skew registers cleared.
- FSM: IDLE -> LOAD on start (num_vec>0); IDLE -> DRAIN on start with num_vec=0; LOAD -> DRAIN after the last element of the last vector; DRAIN -> IDLE after SIZE-1 cycles (0 cycles if num_vec=0).
- Cycle numbering: start sampled at edge E0. Element j of vector k is addressed in the cycle before edge E(1+k*SIZE+j) and captured at that edge.
- Rd_Addr = (base_addr + k*SIZE + j) mod 2^ADDR_WIDTH; wrap past 63 to 0 is legal and silent.
- At the final capture edge of vector k, E((k+1)*SIZE), the full vector (staged elements plus live Rd_Data) enters skew stage 0.
- Lane i of vector k is valid for exactly one cycle, after edge E((k+1)*SIZE+i).
- Lanes not carrying data output value 0 with act_valid bit 0, which zero-fills the array.
- Consecutive vectors are SIZE cycles apart, so lanes never collide.
- Rd_Addr holds its last value outside LOAD.
- busy=1 from after E0 through the cycle in which done=1.
- done=1 in the same cycle the last lane (SIZE-1) of the last vector is valid, i.e. after E(num_vec*SIZE+SIZE-1).
- num_vec=0: no reads, no valids; done after E1.
- start while busy is ignored. start coincident with done is also ignored, because the FSM is not yet IDLE.
- rst mid-job: immediate return to reset values; in-flight lanes are discarded and no done is issued.
- Data pass-through is unmodified: no sign change, no arithmetic.

Optional Feature:
- Macro FEEDER_CYCLE_CNT_EN.
- Defined: adds output port cycle_cnt[15:0].
  - Cleared at the start-accept edge, +1 every busy cycle, saturating at 16'hFFFF.
  - Holds after done until the next start; reset to 0.
  - For num_vec=8, SIZE=8 it reads 71 in the done cycle.
- Undefined: no port and no counter logic; all other behaviour identical.

Decomposition:
- Shared package feeder_pkg:
  - FSM state enum (IDLE, LOAD, DRAIN)
  - UB_DEPTH=64, ADDR_WIDTH=6
  - vector-count width constant
- Sub-module skew_line: parameterised DELAY, data plus valid shift register with synchronous rst, delay 0 as wire. Instantiated per lane in a generate loop.
- The FSM and address counter stay in the top.

Test Plan:
- SIZE=8, AW=7. Buffer preloaded addr a -> value a. start with base_addr=0, num_vec=1:
  - Rd_Addr steps 0..7 over cycles 1..8.
  - Lane i shows value i after E(8+i).
  - done after E15; busy low after E16.
- base_addr=60, num_vec=1 -> reads 60,61,62,63,0,1,2,3 in that order; lanes carry those values.
- num_vec=8, base 0:
  - Lane 0 valid at E8, E16, ..., E64 with values 0, 8, ..., 56.
  - Lane 7 last valid at E71 = done cycle.
  - Never two vectors on one lane in a cycle; idle lanes read 0 with valid 0.
- num_vec=0 -> done after E1, no Rd_Addr change, act_valid stays 0. num_vec=12 behaves exactly as 8.
- start pulsed again at E5 of a running job -> ignored, single done. rst at E10 -> all outputs 0 next cycle, no done. Fresh start afterwards runs normally.
- FEEDER_CYCLE_CNT_EN defined, num_vec=8 -> cycle_cnt=71 during the done cycle, holding afterward.
